// File: rtl/turbo_frame_sched.sv
// Frame scheduler ahead of the turbo encoder: buffers one K-bit frame, then streams
// natural-order (ck) and QPP-interleaved (ckp) bits, followed by a trellis-termination gap.
module turbo_frame_sched #(
    parameter int KMAX        = 6144,
    parameter int ADDR_W      = 13,
    parameter int TAIL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    input  logic len_sel,
    output logic enc_data_valid,
    output logic enc_ck,
    output logic enc_ckp,
    output logic enc_length,
    output logic busy,
    output logic frame_done
);
    localparam int TW = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;

    typedef logic [ADDR_W-1:0] idx_t;
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_TAIL} state_e;

    localparam idx_t ONE        = idx_t'(1);
    localparam idx_t K_SHORT    = idx_t'(1056);
    localparam idx_t F1_SHORT   = idx_t'(17);
    localparam idx_t F2_SHORT   = idx_t'(66);
    localparam idx_t K_LONG     = idx_t'(6144);
    localparam idx_t F1_LONG    = idx_t'(263);
    localparam idx_t F2_LONG    = idx_t'(480);
    localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_CYCLES - 1);
    localparam logic [TW-1:0] TAIL_ONE  = TW'(1);

    state_e state_q, state_d;

    idx_t          wr_idx_q, wr_idx_d;
    idx_t          i_q, i_d;
    idx_t          pi_q, pi_d;
    idx_t          g_q, g_d;
    logic [TW-1:0] tail_q, tail_d;
    logic          len_q, len_d;
    logic          vld_q, vld_d;
    logic          ck_q, ck_d;
    logic          ckp_q, ckp_d;

    logic buf_mem [KMAX];

    idx_t k_cur, f1_cur, f2_cur, f2x2_cur;
    logic accept, last_wr, drain_end;

    // Modular add with a single conditional subtract; both operands are already < k.
    function automatic idx_t mod_add(input idx_t a, input idx_t b, input idx_t k);
        logic [ADDR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) s = s - {1'b0, k};
        return s[ADDR_W-1:0];
    endfunction

    assign k_cur    = len_q ? K_LONG  : K_SHORT;
    assign f1_cur   = len_q ? F1_LONG : F1_SHORT;
    assign f2_cur   = len_q ? F2_LONG : F2_SHORT;
    assign f2x2_cur = {f2_cur[ADDR_W-2:0], 1'b0};

    assign accept    = in_valid & in_ready;
    assign last_wr   = (state_q == S_FILL) && (wr_idx_q == (k_cur - ONE));
    assign drain_end = (i_q == k_cur);

    // Buffer has no reset; contents are only read after a full fill.
    always_ff @(posedge clk) begin
        if (accept) buf_mem[wr_idx_q] <= in_bit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept)                  state_d = S_FILL;
            S_FILL:  if (accept && last_wr)       state_d = S_DRAIN;
            S_DRAIN: if (drain_end)               state_d = S_TAIL;
            S_TAIL:  if (tail_q == TAIL_LAST)     state_d = S_IDLE;
            default:                              state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE) || (state_q == S_FILL);
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_TAIL) && (tail_q == TAIL_LAST);
    end

    always_comb begin
        wr_idx_d = wr_idx_q;
        i_d      = i_q;
        pi_d     = pi_q;
        g_d      = g_q;
        tail_d   = tail_q;
        len_d    = len_q;
        vld_d    = 1'b0;
        ck_d     = 1'b0;
        ckp_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    len_d    = len_sel;
                    wr_idx_d = ONE;
                end
            end
            S_FILL: begin
                if (accept) begin
                    if (last_wr) begin
                        wr_idx_d = '0;
                        i_d      = '0;
                        pi_d     = '0;
                        g_d      = mod_add(f1_cur, f2_cur, k_cur);
                    end else begin
                        wr_idx_d = wr_idx_q + ONE;
                    end
                end
            end
            S_DRAIN: begin
                // i runs to K: the extra cycle clears the registered outputs before TAIL.
                if (drain_end) begin
                    i_d = '0;
                end else begin
                    vld_d = 1'b1;
                    ck_d  = buf_mem[i_q];
                    ckp_d = buf_mem[pi_q];
                    i_d   = i_q + ONE;
                    pi_d  = mod_add(pi_q, g_q, k_cur);
                    g_d   = mod_add(g_q, f2x2_cur, k_cur);
                end
            end
            S_TAIL: begin
                tail_d = (tail_q == TAIL_LAST) ? '0 : tail_q + TAIL_ONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx_q <= '0;
            i_q      <= '0;
            pi_q     <= '0;
            g_q      <= '0;
            tail_q   <= '0;
            len_q    <= 1'b0;
            vld_q    <= 1'b0;
            ck_q     <= 1'b0;
            ckp_q    <= 1'b0;
        end else begin
            wr_idx_q <= wr_idx_d;
            i_q      <= i_d;
            pi_q     <= pi_d;
            g_q      <= g_d;
            tail_q   <= tail_d;
            len_q    <= len_d;
            vld_q    <= vld_d;
            ck_q     <= ck_d;
            ckp_q    <= ckp_d;
        end
    end

    assign enc_data_valid = vld_q;
    assign enc_ck         = ck_q;
    assign enc_ckp        = ckp_q;
    assign enc_length     = len_q;

endmodule

// File: doc/turbo_frame_sched.md
Name: turbo_frame_sched

Overview:
Frame scheduler that sits in front of the turbo encoder top level. It buffers one information frame of K bits, then streams it to the encoder. Each cycle it presents the natural-order bit as ck and the QPP-interleaved bit as ckp. After the frame it holds off the next frame for the trellis-termination window, then signals completion.

Parameters:
KMAX, 6144, largest supported frame length and buffer depth in bits
ADDR_W, 13, index width; must satisfy 2^ADDR_W >= KMAX
TAIL_CYCLES, 4, idle cycles after the last data bit reserved for trellis termination

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
in_valid  input  1  upstream bit valid
in_bit  input  1  upstream information bit
in_ready  output  1  scheduler can accept a bit this cycle
len_sel  input  1  frame length select: 0 -> K=1056, 1 -> K=6144
enc_data_valid  output  1  to encoder data_valid
enc_ck  output  1  to encoder ck (natural order)
enc_ckp  output  1  to encoder ckp (interleaved order)
enc_length  output  1  to encoder length flag (latched len_sel)
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse at end of TAIL

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all counters 0; in_ready=1; enc_data_valid, enc_ck, enc_ckp, enc_length, busy and frame_done all 0. Buffer contents are don't-care.
- States: IDLE, FILL, DRAIN, TAIL.
- IDLE:
  - in_ready=1.
  - On an accepted bit (in_valid&in_ready), write buf[0], latch len_sel into enc_length and K, set wr_idx=1, go to FILL.
- FILL:
  - in_ready=1.
  - Each accepted bit writes buf[wr_idx] and increments wr_idx.
  - The edge accepting bit K-1 moves to DRAIN with i=0, pi=0, g=(f1+f2) mod K.
  - Gaps in in_valid stall FILL indefinitely.
  - len_sel is ignored after the first bit.
- DRAIN:
  - in_ready=0.
  - Outputs are registered. The edge that leaves FILL is edge E.
  - At edge E+1+n, for n=0..K-1: enc_data_valid=1, enc_ck=buf[n], enc_ckp=buf[pi(n)].
  - enc_data_valid is high for exactly K contiguous cycles.
  - After the n=K-1 update, go to TAIL.
- QPP index recursion, no multipliers:
  - pi(n+1) = (pi(n)+g(n)) mod K; g(n+1) = (g(n)+2*f2) mod K.
  - Each mod is a single conditional subtract of K. Operands are < K; intermediate width is ADDR_W+1.
  - K=1056: f1=17, f2=66. K=6144: f1=263, f2=480.
- TAIL:
  - enc_data_valid=0, enc_ck=0, enc_ckp=0, in_ready=0, enc_length held.
  - Lasts TAIL_CYCLES cycles. On the last TAIL cycle frame_done=1 for one cycle, then go to IDLE.
- busy=1 in FILL/DRAIN/TAIL.
- in_ready is combinational from state only.
- in_valid while in_ready=0 is ignored; upstream must hold the bit.
- Back-to-back frames: first bit of the next frame is accepted the cycle after frame_done.
- enc_length stays stable from first bit of a frame through TAIL; it changes only when the next frame's first bit is accepted.
- rst asserted mid-FILL/DRAIN/TAIL: immediate return to IDLE with reset outputs. The partial frame is discarded and no frame_done is produced.

Test Plan:
- K=1056, bit 83 only set -> enc_ckp=1 only at n=1 (pi(1)=83); enc_ck=1 only at n=83; enc_data_valid high exactly 1056 cycles.
- K=6144, bits 0, 743 and 2446 set -> enc_ckp=1 at n=0,1,2 and nowhere else; enc_length=1 throughout; frame_done exactly 4 cycles after enc_data_valid falls.
- K=1056, random data with in_valid toggling every other cycle -> enc_ck stream equals input order; stalls do not corrupt the buffer; full pi sequence matches the reference model (f1*i+f2*i^2) mod K for all i.
- Two frames back to back, 1056 then 6144 -> second frame's first bit accepted on the cycle after frame_done; enc_length switches 0->1 only then; in_ready=0 throughout DRAIN/TAIL.
- rst pulsed at n=500 of DRAIN -> outputs 0 asynchronously, state IDLE, in_ready=1; the following full frame encodes correctly.
- len_sel toggled during FILL -> no effect on K, enc_length or interleaving of the current frame.
